// File: rtl/ovr_i_monitor_pkg.sv
// -----------------------------------------------------------------------------
// ovr_i_monitor_pkg
// Shared types and constants for the per-channel over-current supervisor.
//   ovr_state_t   : supervisor state (NORMAL / TRIPPED)
//   OVR_CNT_W     : width of the consecutive offending-period counter
//   FILT_CNT_W    : width of the glitch-filter counter (holds up to 4)
//   OVR_LIMIT_DEF : default number of offending periods that trip shutdown
//   FILT_LEN_DEF  : default number of unblanked clocks that qualify an event
// -----------------------------------------------------------------------------
package ovr_i_monitor_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        TRIPPED = 1'b1
    } ovr_state_t;

    localparam int OVR_CNT_W     = 4;
    localparam int FILT_CNT_W    = 3;
    localparam int OVR_LIMIT_DEF = 4;
    localparam int FILT_LEN_DEF  = 2;

endpackage

// File: rtl/ovr_i_monitor_if.sv
// -----------------------------------------------------------------------------
// ovr_i_monitor_if
// Bundles the PWM-side inputs and supervisor outputs of one motor channel.
//   OVR_I       : raw comparator flag (asynchronous to clk)
//   ovr_I_blank : blanking window, events ignored while high
//   PWM_synch   : one-cycle pulse at each PWM period boundary
//   clr_shutdn  : synchronous clear of trip and history
//   ovr_evt     : one-cycle pulse per newly qualified event
//   ovr_cnt     : consecutive offending-period count
//   ovr_shutdn  : latched shutdown request
// master = PWM generator / controller side, slave = supervisor side.
// -----------------------------------------------------------------------------
interface ovr_i_monitor_if;
    import ovr_i_monitor_pkg::*;

    logic                 OVR_I;
    logic                 ovr_I_blank;
    logic                 PWM_synch;
    logic                 clr_shutdn;
    logic                 ovr_evt;
    logic [OVR_CNT_W-1:0] ovr_cnt;
    logic                 ovr_shutdn;

    modport master (
        output OVR_I, ovr_I_blank, PWM_synch, clr_shutdn,
        input  ovr_evt, ovr_cnt, ovr_shutdn
    );

    modport slave (
        input  OVR_I, ovr_I_blank, PWM_synch, clr_shutdn,
        output ovr_evt, ovr_cnt, ovr_shutdn
    );

endinterface

// File: rtl/ovr_i_monitor_sync2.sv
// -----------------------------------------------------------------------------
// ovr_i_monitor_sync2
// Generic two-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   i_d : asynchronous input, feeds the first flop directly
//   o_q : synchronised output, two clocks after i_d
// -----------------------------------------------------------------------------
module ovr_i_monitor_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // two-stage capture; nothing combinational ahead of r_meta
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ovr_i_monitor.sv
// -----------------------------------------------------------------------------
// ovr_i_monitor
// Over-current supervisor for one motor channel. Synchronises the comparator
// flag, rejects glitches and blanked samples, counts consecutive PWM periods
// that contain a qualified event and latches a shutdown request once the count
// reaches OVR_LIMIT. The request holds until clr_shutdn or rst.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : ovr_i_monitor_if.slave (OVR_I, ovr_I_blank, PWM_synch, clr_shutdn
//         in; ovr_evt, ovr_cnt, ovr_shutdn out)
// Parameters: OVR_LIMIT (1..15), FILT_LEN (1..4).
// -----------------------------------------------------------------------------
module ovr_i_monitor
    import ovr_i_monitor_pkg::*;
#(
    parameter int OVR_LIMIT = OVR_LIMIT_DEF,
    parameter int FILT_LEN  = FILT_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ovr_i_monitor_if.slave bus
);

    localparam logic [FILT_CNT_W-1:0] FILT_MAX = FILT_CNT_W'(FILT_LEN);
    localparam logic [OVR_CNT_W-1:0]  CNT_MAX  = OVR_CNT_W'(OVR_LIMIT);
    localparam logic [OVR_CNT_W-1:0]  CNT_PRE  = OVR_CNT_W'(OVR_LIMIT - 1);

    // the count is held in OVR_CNT_W bits, so the limit must fit there
    if ((OVR_LIMIT < 1) || (OVR_LIMIT > 15)) begin : g_bad_limit
        $error("ovr_i_monitor: OVR_LIMIT must be within 1..15");
    end
    if ((FILT_LEN < 1) || (FILT_LEN > 4)) begin : g_bad_filt
        $error("ovr_i_monitor: FILT_LEN must be within 1..4");
    end

    logic                  w_ovr_s;
    logic                  w_unbl;
    logic                  w_filt_full;
    logic                  w_qual;

    logic [FILT_CNT_W-1:0] r_filt_cnt;
    logic                  r_filt_full_d;
    logic                  r_ovr_evt;
    logic                  r_period_flag;
    logic [OVR_CNT_W-1:0]  r_ovr_cnt;
    logic                  r_ovr_shutdn;
    ovr_state_t            r_state;

    ovr_i_monitor_sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (bus.OVR_I),
        .o_q (w_ovr_s)
    );

    assign w_unbl      = w_ovr_s & ~bus.ovr_I_blank;
    assign w_filt_full = (r_filt_cnt == FILT_MAX);
    // qualify only in the first cycle the filter sits at FILT_LEN, so one
    // contiguous unblanked run yields exactly one event
    assign w_qual      = w_filt_full & ~r_filt_full_d;

    // glitch filter and event pulse; a clear wipes the filter and drops a
    // coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_cnt    <= 3'd0;
            r_filt_full_d <= 1'b0;
            r_ovr_evt     <= 1'b0;
        end else if (bus.clr_shutdn) begin
            r_filt_cnt    <= 3'd0;
            r_filt_full_d <= 1'b0;
            r_ovr_evt     <= 1'b0;
        end else begin
            r_filt_full_d <= w_filt_full;
            r_ovr_evt     <= w_qual;
            if (!w_unbl) begin
                r_filt_cnt <= 3'd0;
            end else if (!w_filt_full) begin
                r_filt_cnt <= r_filt_cnt + 3'd1;
            end else begin
                r_filt_cnt <= r_filt_cnt;
            end
        end
    end

    // supervisor FSM with period flag, consecutive-period counter and
    // registered shutdown decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= NORMAL;
            r_period_flag <= 1'b0;
            r_ovr_cnt     <= 4'd0;
            r_ovr_shutdn  <= 1'b0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (bus.clr_shutdn) begin
                        // clear outranks a coincident boundary or event
                        r_period_flag <= 1'b0;
                        r_ovr_cnt     <= 4'd0;
                        r_ovr_shutdn  <= 1'b0;
                    end else if (bus.PWM_synch) begin
                        if (r_period_flag && (r_ovr_cnt == CNT_PRE)) begin
                            r_state       <= TRIPPED;
                            r_ovr_cnt     <= CNT_MAX;
                            r_period_flag <= 1'b0;
                            r_ovr_shutdn  <= 1'b1;
                        end else if (r_period_flag) begin
                            // boundary cycle's own event opens the new period
                            r_period_flag <= w_qual;
                            if (r_ovr_cnt < CNT_MAX) begin
                                r_ovr_cnt <= r_ovr_cnt + 4'd1;
                            end else begin
                                r_ovr_cnt <= CNT_MAX;
                            end
                        end else begin
                            // a clean period breaks the consecutive run
                            r_period_flag <= w_qual;
                            r_ovr_cnt     <= 4'd0;
                        end
                    end else begin
                        r_period_flag <= r_period_flag | w_qual;
                    end
                end
                TRIPPED: begin
                    r_period_flag <= 1'b0;
                    if (bus.clr_shutdn) begin
                        r_state      <= NORMAL;
                        r_ovr_cnt    <= 4'd0;
                        r_ovr_shutdn <= 1'b0;
                    end else begin
                        r_ovr_cnt    <= CNT_MAX;
                        r_ovr_shutdn <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= NORMAL;
                    r_period_flag <= 1'b0;
                    r_ovr_cnt     <= 4'd0;
                    r_ovr_shutdn  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ovr_evt    = r_ovr_evt;
    assign bus.ovr_cnt    = r_ovr_cnt;
    assign bus.ovr_shutdn = r_ovr_shutdn;

endmodule

// File: tb/tb_ovr_i_monitor.sv
// -----------------------------------------------------------------------------
// tb_ovr_i_monitor
// Self-checking bench for ovr_i_monitor. The reference model derives events
// from the history of applied inputs (sync delay, unblanked run length) and
// tracks the offending-period rules with plain integers.
// -----------------------------------------------------------------------------
module tb_ovr_i_monitor;
    import ovr_i_monitor_pkg::*;

    localparam int LIM = 4;
    localparam int FL  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ovr_i_monitor_if bus ();

    ovr_i_monitor #(
        .OVR_LIMIT (LIM),
        .FILT_LEN  (FL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    bit   m_d1, m_d2;      // OVR_I applied one and two cycles ago
    int   m_run;           // length of the current unblanked-high run (capped)
    bit   m_trip;
    int   m_cnt;
    bit   m_pend;          // current period already holds an event
    bit   e_evt;
    logic [3:0] e_cnt;
    bit   e_shut;

    task automatic model_clear();
        m_d1 = 1'b0; m_d2 = 1'b0; m_run = 0;
        m_trip = 1'b0; m_cnt = 0; m_pend = 1'b0;
        e_evt = 1'b0; e_cnt = 4'd0; e_shut = 1'b0;
    endtask

    // drive one cycle of inputs, advance the model, sample #1 after the edge
    task automatic tick(input bit ovr, input bit blk, input bit syn, input bit clr);
        bit ovr_s, unbl, qual;
        bus.OVR_I = ovr; bus.ovr_I_blank = blk; bus.PWM_synch = syn; bus.clr_shutdn = clr;
        ovr_s = m_d2;
        m_d2  = m_d1;
        m_d1  = ovr;
        unbl  = ovr_s && !blk;
        qual  = (m_run == FL);
        m_run = (unbl && !clr) ? ((m_run > FL) ? m_run : m_run + 1) : 0;
        if (m_trip) begin
            if (clr) begin m_trip = 1'b0; m_cnt = 0; m_pend = 1'b0; end
        end else if (clr) begin
            m_cnt = 0; m_pend = 1'b0;
        end else if (syn) begin
            m_cnt  = m_pend ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
            m_trip = (m_cnt == LIM);
            m_pend = qual && !m_trip;
        end else begin
            m_pend = m_pend || qual;
        end
        e_evt  = qual && !clr;
        e_cnt  = 4'(m_cnt);
        e_shut = m_trip;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.OVR_I = 1'b0; bus.ovr_I_blank = 1'b0; bus.PWM_synch = 1'b0; bus.clr_shutdn = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // quiet cycles followed by a clear so a test starts from empty history
    task automatic settle();
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // one 16-cycle PWM period, boundary pulse in the last cycle
    task automatic period(input bit ev, input bit clr_last);
        int pos, w;
        pos = $urandom_range(1, 6);
        w   = $urandom_range(FL, FL + 2);
        for (int c = 0; c < 16; c++)
            tick(ev && (c >= pos) && (c < pos + w), c == 0, c == 15, clr_last && (c == 15));
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.ovr_evt !== 1'b0) begin n_bad++; $display("FAIL reset_evt got %b want 0", bus.ovr_evt); end
        n_cmp++; if (bus.ovr_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", bus.ovr_cnt); end
        n_cmp++; if (bus.ovr_shutdn !== 1'b0) begin n_bad++; $display("FAIL reset_shutdn got %b want 0", bus.ovr_shutdn); end
    endtask

    task automatic test_idle();
        int evts = 0;
        for (int c = 0; c < 48; c++) begin
            tick(1'b0, (c % 16) < 3, (c % 16) == 15, 1'b0);
            evts += int'(bus.ovr_evt);
            n_cmp++;
            if (bus.ovr_evt !== e_evt || bus.ovr_cnt !== e_cnt || bus.ovr_shutdn !== e_shut) begin
                n_bad++;
                $display("FAIL idle c%0d got evt=%b cnt=%0d shut=%b want evt=%b cnt=%0d shut=%b",
                         c, bus.ovr_evt, bus.ovr_cnt, bus.ovr_shutdn, e_evt, e_cnt, e_shut);
            end
        end
        n_cmp++; if (evts != 0) begin n_bad++; $display("FAIL idle_evts got %0d want 0", evts); end
        n_cmp++; if (bus.ovr_cnt !== 4'd0) begin n_bad++; $display("FAIL idle_cnt got %0d want 0", bus.ovr_cnt); end
    endtask

    task automatic test_blanked();
        int evts = 0;
        for (int c = 0; c < 160; c++) begin
            tick(((c % 16) >= 1) && ((c % 16) <= 5) && ($urandom_range(0, 3) != 0),
                 (c % 16) < 8, (c % 16) == 15, 1'b0);
            evts += int'(bus.ovr_evt);
            n_cmp++;
            if (bus.ovr_evt !== e_evt || bus.ovr_cnt !== e_cnt || bus.ovr_shutdn !== e_shut) begin
                n_bad++;
                $display("FAIL blanked c%0d got evt=%b cnt=%0d shut=%b want evt=%b cnt=%0d shut=%b",
                         c, bus.ovr_evt, bus.ovr_cnt, bus.ovr_shutdn, e_evt, e_cnt, e_shut);
            end
        end
        n_cmp++; if (evts != 0) begin n_bad++; $display("FAIL blanked_evts got %0d want 0", evts); end
        n_cmp++; if (bus.ovr_cnt !== 4'd0) begin n_bad++; $display("FAIL blanked_cnt got %0d want 0", bus.ovr_cnt); end
    endtask

    task automatic test_glitch();
        int evts = 0;
        int first = 0;
        settle();
        for (int i = 1; i <= 12; i++) begin
            tick(i == 1, 1'b0, 1'b0, 1'b0);
            evts += int'(bus.ovr_evt);
        end
        n_cmp++; if (evts != 0) begin n_bad++; $display("FAIL glitch_1clk evts got %0d want 0", evts); end
        evts = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(i <= 2, 1'b0, 1'b0, 1'b0);
            if (bus.ovr_evt === 1'b1 && first == 0) first = i;
            evts += int'(bus.ovr_evt);
        end
        n_cmp++; if (evts != 1) begin n_bad++; $display("FAIL glitch_2clk evts got %0d want 1", evts); end
        n_cmp++; if (first != 5) begin n_bad++; $display("FAIL evt_latency got %0d want 5", first); end
    endtask

    task automatic test_trip();
        settle();
        for (int p = 1; p <= 4; p++) begin
            period(1'b1, 1'b0);
            n_cmp++;
            if (bus.ovr_cnt !== 4'(p) || bus.ovr_shutdn !== (p == 4)) begin
                n_bad++;
                $display("FAIL trip_p%0d got cnt=%0d shut=%b want cnt=%0d shut=%b",
                         p, bus.ovr_cnt, bus.ovr_shutdn, p, p == 4);
            end
        end
        period(1'b1, 1'b0);
        period(1'b0, 1'b0);
        n_cmp++;
        if (bus.ovr_cnt !== 4'd4 || bus.ovr_shutdn !== 1'b1 || bus.ovr_cnt !== e_cnt) begin
            n_bad++;
            $display("FAIL trip_frozen got cnt=%0d shut=%b want cnt=4 shut=1", bus.ovr_cnt, bus.ovr_shutdn);
        end
    endtask

    task automatic test_run_broken();
        settle();
        for (int p = 1; p <= 4; p++) period(p != 4, 1'b0);
        n_cmp++;
        if (bus.ovr_cnt !== 4'd0 || bus.ovr_shutdn !== 1'b0) begin
            n_bad++;
            $display("FAIL run_broken got cnt=%0d shut=%b want cnt=0 shut=0", bus.ovr_cnt, bus.ovr_shutdn);
        end
        for (int p = 1; p <= 4; p++) period(1'b1, 1'b0);
        n_cmp++;
        if (bus.ovr_cnt !== 4'd4 || bus.ovr_shutdn !== 1'b1) begin
            n_bad++;
            $display("FAIL run_retrip got cnt=%0d shut=%b want cnt=4 shut=1", bus.ovr_cnt, bus.ovr_shutdn);
        end
    endtask

    task automatic test_clear();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.ovr_cnt !== 4'd0 || bus.ovr_shutdn !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_tripped got cnt=%0d shut=%b want cnt=0 shut=0", bus.ovr_cnt, bus.ovr_shutdn);
        end
        settle();
        for (int p = 1; p <= 3; p++) period(1'b1, 1'b0);
        n_cmp++; if (bus.ovr_cnt !== 4'd3) begin n_bad++; $display("FAIL clr_pre got cnt=%0d want 3", bus.ovr_cnt); end
        period(1'b1, 1'b1);
        n_cmp++;
        if (bus.ovr_cnt !== 4'd0 || bus.ovr_shutdn !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_vs_synch got cnt=%0d shut=%b want cnt=0 shut=0", bus.ovr_cnt, bus.ovr_shutdn);
        end
        for (int p = 1; p <= 4; p++) period(1'b1, 1'b0);
        n_cmp++; if (bus.ovr_shutdn !== 1'b1) begin n_bad++; $display("FAIL clr_retrip got shut=%b want 1", bus.ovr_shutdn); end
        // asynchronous reset while tripped: shutdown must drop before any edge
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.ovr_shutdn !== 1'b0 || bus.ovr_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_tripped got cnt=%0d shut=%b want cnt=0 shut=0", bus.ovr_cnt, bus.ovr_shutdn);
        end
        apply_reset();
    endtask

    task automatic test_random();
        int  plen = 12;
        int  ph = 0;
        bit  lvl = 1'b0;
        int  trips = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) lvl = ($urandom_range(0, 9) < 6);
            tick(lvl, ph < 2, ph == plen - 1, $urandom_range(0, 199) == 0);
            trips += int'(e_shut);
            n_cmp++;
            if (bus.ovr_evt !== e_evt || bus.ovr_cnt !== e_cnt || bus.ovr_shutdn !== e_shut) begin
                n_bad++;
                $display("FAIL random c%0d got evt=%b cnt=%0d shut=%b want evt=%b cnt=%0d shut=%b",
                         c, bus.ovr_evt, bus.ovr_cnt, bus.ovr_shutdn, e_evt, e_cnt, e_shut);
            end
            ph++;
            if (ph == plen) begin
                ph = 0;
                plen = $urandom_range(8, 20);
            end
        end
        $display("random phase: %0d cycles with shutdown expected", trips);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_idle();
        test_blanked();
        test_glitch();
        test_trip();
        test_run_broken();
        test_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ovr_i_monitor.md
Name: ovr_i_monitor

Overview:
Over-current supervisor sitting directly downstream of the 11-bit PWM generator, one instance per motor channel.
- Consumes PWM_synch and ovr_I_blank from the PWM generator, plus the raw asynchronous comparator output OVR_I.
- Counts PWM periods that contain a qualified, unblanked over-current event.
- Latches a shutdown request after OVR_LIMIT consecutive offending periods; the request holds until explicitly cleared.

Parameters:
OVR_LIMIT, 4, consecutive offending PWM periods that trip shutdown (legal range 1..15).
FILT_LEN, 2, consecutive unblanked high clocks needed to qualify an event (legal range 1..4).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
OVR_I  in  1  raw comparator over-current flag, asynchronous to clk
ovr_I_blank  in  1  blanking window from the PWM generator; events are ignored while high
PWM_synch  in  1  single-cycle pulse at PWM counter == 0, marking a period boundary
clr_shutdn  in  1  synchronous pulse that clears the trip and all history
ovr_evt  out  1  one-cycle pulse on each newly qualified event
ovr_cnt  out  4  current consecutive offending-period count (zero-extended)
ovr_shutdn  out  1  latched shutdown request to the motor driver

Behaviour:
- Reset (async, rst=1): all flops cleared.
  - Sync chain = 0, filter counter = 0, period_flag = 0, ovr_cnt = 0.
  - FSM = NORMAL, ovr_evt = 0, ovr_shutdn = 0.
- Synchroniser:
  - OVR_I passes through 2 flops to give ovr_s.
  - No logic is allowed before the first flop.
- Filter:
  - unbl = ovr_s & ~ovr_I_blank.
  - filt_cnt increments while unbl=1, saturating at FILT_LEN; it resets to 0 when unbl=0.
  - qual = 1 in the cycle filt_cnt transitions to FILT_LEN.
  - At most one qual per contiguous unblanked-high run.
  - ovr_evt is qual registered, so it pulses 1 cycle after qual.
- Latency:
  - OVR_I rising edge to ovr_evt: 2 sync clocks + FILT_LEN clocks + 1, i.e. 5 clocks at the defaults.
- period_flag (sticky within a period):
  - Non-synch cycle: period_flag <= period_flag | qual.
  - PWM_synch cycle: period_flag <= qual. A new period starts with that cycle's event; the old flag is consumed.
- Counter update, only on PWM_synch cycles while the FSM is in NORMAL:
  - period_flag=1: ovr_cnt <= ovr_cnt+1, saturating at OVR_LIMIT.
  - period_flag=0: ovr_cnt <= 0. Any clean period breaks the consecutive run.
- FSM, 2 states:
  - NORMAL -> TRIPPED when PWM_synch=1, period_flag=1 and ovr_cnt == OVR_LIMIT-1.
    - ovr_cnt reaches OVR_LIMIT in the same edge.
    - ovr_shutdn rises on the edge entering TRIPPED, i.e. it is the registered state decode.
  - TRIPPED: ovr_cnt frozen at OVR_LIMIT and period_flag held at 0.
    - ovr_evt still reports new qualified events (diagnostics).
    - PWM_synch has no effect.
  - TRIPPED -> NORMAL on clr_shutdn=1; ovr_cnt, period_flag and filt_cnt are cleared on the same edge.
- Simultaneous events:
  - clr_shutdn in NORMAL clears ovr_cnt and period_flag and suppresses any trip or count in that cycle. clr beats PWM_synch.
  - clr_shutdn and qual in the same cycle: the event is discarded.
- Blank asserted mid-run: filt_cnt resets; the event must re-qualify with FILT_LEN fresh unblanked clocks.
- Reset mid-operation (including while TRIPPED): immediate return to the reset values above; shutdown drops asynchronously.
- Width rule: ovr_cnt is computed at 4 bits; OVR_LIMIT outside 1..15 is a compile-time error (elaboration assertion).

Decomposition:
- Shared package holds:
  - typedef enum logic {NORMAL, TRIPPED} ovr_state_t;
  - localparam OVR_CNT_W = 4;
  - default OVR_LIMIT/FILT_LEN constants used by the motor-drive top.
- Sub-module: sync2 (generic 2-flop synchroniser, async active-high reset).
  - Reused later for other comparator inputs.
  - Filter, period logic and FSM stay inline.

Test Plan:
1. Reset then idle: OVR_I=0 for 3 PWM periods -> ovr_cnt=0, ovr_shutdn=0, ovr_evt never pulses.
2. Blanked event: OVR_I=1 only while ovr_I_blank=1, for 10 periods -> no ovr_evt, ovr_cnt stays 0.
3. Glitch rejection: unblanked OVR_I high for exactly 1 clock (after sync) -> no ovr_evt. Held 2 clocks -> ovr_evt pulses once, 5 clocks after the OVR_I edge.
4. Trip: qualified event in 4 consecutive periods -> ovr_cnt 1,2,3 at successive PWM_synch. ovr_shutdn=1 the edge after the 4th synch with ovr_cnt=4; further synchs leave ovr_cnt=4.
5. Run broken: events in periods 1,2,3, period 4 clean -> ovr_cnt returns to 0 at 4th synch, no trip. Then 4 more offending periods -> trip.
6. Clear/reset corners: clr_shutdn while TRIPPED -> ovr_shutdn=0, ovr_cnt=0 next edge. clr_shutdn coincident with PWM_synch at ovr_cnt=3 with flag set -> no trip, ovr_cnt=0. rst asserted in TRIPPED -> ovr_shutdn=0 immediately.
